// File: rtl/sv_param_fifo.sv
// sv_param_fifo: single-clock FWFT FIFO with valid/ready on both sides,
// occupancy count, registered almost-full/almost-empty and sticky error flags.
module sv_param_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             err_ovf,
    output logic             err_udf
);

    // Pointer width; DEPTH >= 2 keeps this at least one bit.
    localparam int PW = $clog2(DEPTH);

    // Reject parameter sets that would make the thresholds or storage meaningless.
    if (DEPTH < 2) begin : g_chk_depth
        $fatal(1, "sv_param_fifo: DEPTH must be >= 2");
    end
    if (WIDTH < 1) begin : g_chk_width
        $fatal(1, "sv_param_fifo: WIDTH must be >= 1");
    end
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_chk_levels
        $fatal(1, "sv_param_fifo: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic             full, empty;
    logic             push, pop;

    // Full/empty come from the registered count only, so the handshake
    // outputs never depend combinationally on s_valid or m_ready.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign s_ready = ~full;
    assign m_valid = ~empty;
    assign push    = s_valid & ~full;
    assign pop     = m_ready & ~empty;

    // First-word-fall-through: the head entry is always on m_data.
    assign m_data = mem[rd_ptr];

    // Next pointer/count values; pointers wrap explicitly since DEPTH need
    // not be a power of two.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (clr) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push)
                wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr_ptr] <= s_data;
    end

    // Pointer, count and threshold registers; thresholds track the new count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
        end
    end

    // Sticky error flags for dropped requests; only clr or reset clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else if (clr) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (s_valid && full)
                err_ovf <= 1'b1;
            if (m_ready && empty)
                err_udf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sv_param_fifo.sv
// Bench for sv_param_fifo: queue-based reference model checked every cycle,
// plus directed literal checks of the key scenarios.
module tb_sv_param_fifo;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int AE_LEVEL = 2;
    localparam int CW       = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             s_valid = 1'b0;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_ready;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready = 1'b0;
    logic [CW-1:0]    count;
    logic             almost_full, almost_empty, err_ovf, err_udf;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    sv_param_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a queue of words plus two sticky bits.
    logic [WIDTH-1:0] q[$];
    bit mdl_ovf = 1'b0, mdl_udf = 1'b0;
    bit mdl_full, mdl_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            q.delete();
            mdl_ovf = 1'b0;
            mdl_udf = 1'b0;
        end else begin
            mdl_full  = (q.size() == DEPTH);
            mdl_empty = (q.size() == 0);
            if (s_valid && mdl_full)  mdl_ovf = 1'b1;
            if (m_ready && mdl_empty) mdl_udf = 1'b1;
            if (m_ready && !mdl_empty) void'(q.pop_front());
            if (s_valid && !mdl_full)  q.push_back(s_data);
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        chk("m_count",   32'(count),        32'(q.size()));
        chk("m_s_ready", 32'(s_ready),      32'(q.size() < DEPTH));
        chk("m_m_valid", 32'(m_valid),      32'(q.size() > 0));
        chk("m_af",      32'(almost_full),  32'(q.size() >= AF_LEVEL));
        chk("m_ae",      32'(almost_empty), 32'(q.size() <= AE_LEVEL));
        chk("m_ovf",     32'(err_ovf),      32'(mdl_ovf));
        chk("m_udf",     32'(err_udf),      32'(mdl_udf));
        if (q.size() > 0) chk("m_data", 32'(m_data), 32'(q[0]));
    end

    // One clock of stimulus; outputs are settled when this returns.
    task automatic cyc(input logic sv, input logic [WIDTH-1:0] sd,
                       input logic mr, input logic cl);
        s_valid = sv; s_data = sd; m_ready = mr; clr = cl;
        @(posedge clk);
        #1;
        s_valid = 1'b0; m_ready = 1'b0; clr = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(0, '0, 0, 0);
        // Reset/idle state
        chk("rst_count", 32'(count), 0);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_ovf", 32'(err_ovf), 0);
        chk("rst_udf", 32'(err_udf), 0);

        // Fill with m_ready low
        for (int i = 0; i < 8; i++) begin
            cyc(1, 16'h1000 + 16'(i), 0, 0);
            if (i == 4) chk("af_at5", 32'(almost_full), 0);
            if (i == 5) chk("af_at6", 32'(almost_full), 1);
        end
        chk("full_count", 32'(count), 8);
        chk("full_s_ready", 32'(s_ready), 0);
        cyc(1, 16'hDEAD, 0, 0);
        chk("ovf_set", 32'(err_ovf), 1);
        chk("ovf_count", 32'(count), 8);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", 32'(m_data), 32'h1000 + 32'(i));
            cyc(0, '0, 1, 0);
            chk("drain_ae", 32'(almost_empty), 32'((7 - i) <= 2));
        end
        chk("drain_m_valid", 32'(m_valid), 0);

        // Clear stale ovf, then steady-state push+pop across pointer wrap
        cyc(0, '0, 0, 1);
        chk("clr_ovf", 32'(err_ovf), 0);
        for (int i = 0; i < 4; i++) cyc(1, 16'h2000 + 16'(i), 0, 0);
        for (int i = 0; i < 20; i++) begin
            chk("wrap_data", 32'(m_data), 32'h2000 + 32'(i));
            cyc(1, 16'h2004 + 16'(i), 1, 0);
            chk("wrap_count", 32'(count), 4);
        end
        chk("wrap_ovf", 32'(err_ovf), 0);
        chk("wrap_udf", 32'(err_udf), 0);

        // Underflow then clear
        for (int i = 0; i < 4; i++) begin
            chk("tail_data", 32'(m_data), 32'h2014 + 32'(i));
            cyc(0, '0, 1, 0);
        end
        cyc(0, '0, 1, 0);
        chk("udf_set", 32'(err_udf), 1);
        chk("udf_count", 32'(count), 0);
        cyc(0, '0, 0, 1);
        chk("udf_clr", 32'(err_udf), 0);

        // clr beats simultaneous push and pop
        for (int i = 0; i < 5; i++) cyc(1, 16'h3000 + 16'(i), 0, 0);
        chk("pre_clr_count", 32'(count), 5);
        cyc(1, 16'hBEEF, 1, 1);
        chk("clr_count", 32'(count), 0);
        chk("clr_m_valid", 32'(m_valid), 0);
        cyc(0, '0, 0, 0);
        chk("clr_no_accept", 32'(count), 0);

        // Async reset mid-burst with the FIFO full and ovf set
        for (int i = 0; i < 9; i++) cyc(1, 16'h4000 + 16'(i), 0, 0);
        chk("pre_rst_ovf", 32'(err_ovf), 1);
        s_valid = 1'b1; s_data = 16'h4444;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_s_ready", 32'(s_ready), 1);
        chk("arst_m_valid", 32'(m_valid), 0);
        chk("arst_af", 32'(almost_full), 0);
        chk("arst_ae", 32'(almost_empty), 1);
        chk("arst_ovf", 32'(err_ovf), 0);
        @(posedge clk);
        #1 s_valid = 1'b0; rst_n = 1'b1;
        cyc(0, '0, 0, 0);
        chk("post_rst_count", 32'(count), 0);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
